// File: rtl/conv_pkg.sv
// Shared definitions for the radix convolutional encoder: widest supported
// constraint length, frame FSM states and the generator parity helper.
package conv_pkg;

  // Widest constraint length any instance may be built with.
  localparam int K_MAX = 9;

  // Frame sequencing: waiting for start, consuming data beats, flushing zeros.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_TAIL = 2'd2
  } conv_fsm_e;

  // One generator output: parity of the shift-register taps selected by poly.
  // Callers zero-extend narrower codes so one helper serves every K.
  function automatic logic conv_parity(input logic [K_MAX-1:0] sr,
                                       input logic [K_MAX-1:0] poly);
    return ^(sr & poly);
  endfunction

endpackage

// File: rtl/conv_step.sv
// Single-bit encoder step: shifts one input bit into the state and produces
// the N_POLY generator outputs for it. Chained RADIX_BITS times per beat.
module conv_step
  import conv_pkg::*;
#(
  parameter int K      = 9,
  parameter int N_POLY = 2
) (
  input  logic [K-2:0]        state_i,
  input  logic                bit_i,
  input  logic [N_POLY*K-1:0] poly_i,
  output logic [N_POLY-1:0]   code_o,
  output logic [K-2:0]        state_o
);

  // Full register window: current bit on top, oldest state bit at 0.
  logic [K-1:0] sr;

  assign sr      = {bit_i, state_i};
  assign state_o = sr[K-1:1];

  // Generator 0 lands in the MSB of the group.
  genvar gi;
  generate
    for (gi = 0; gi < N_POLY; gi++) begin : g_gen
      assign code_o[N_POLY-1-gi] = conv_parity(K_MAX'(sr), K_MAX'(poly_i[gi*K +: K]));
    end
  endgenerate

endmodule

// File: rtl/conv_encoder_radix.sv
// Framed, streaming rate-1/N_POLY convolutional encoder consuming RADIX_BITS
// bits per beat with optional zero-tail termination. Each output beat carries
// the code word plus the encoder state reached after that beat.
module conv_encoder_radix
  import conv_pkg::*;
#(
  parameter int K          = 9,
  parameter int N_POLY     = 2,
  parameter int RADIX_BITS = 2,
  parameter int LEN_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en_conv,
  input  logic                         start,
  input  logic [LEN_W-1:0]             frame_len,
  input  logic                         mode_select,
  input  logic [N_POLY*K-1:0]          polynomial,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [RADIX_BITS-1:0]        i_bit,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [RADIX_BITS*N_POLY-1:0] code_word,
  output logic [K-2:0]                 out_state,
  output logic                         out_last,
  output logic                         busy
);

  localparam int CW         = RADIX_BITS * N_POLY;
  // Enough zero bits to flush all K-1 state bits; partial beats are padded.
  localparam int TAIL_BEATS = (K - 1 + RADIX_BITS - 1) / RADIX_BITS;
  localparam int TC_W       = $clog2(TAIL_BEATS + 1);
  localparam logic [TC_W-1:0] TAIL_LAST = TC_W'(TAIL_BEATS - 1);

  // Frame control and latched parameters
  conv_fsm_e             fsm_q;
  logic [N_POLY*K-1:0]   poly_q;
  logic                  mode_q;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic [TC_W-1:0]       tail_q, tail_d;
  logic [K-2:0]          enc_state_q, enc_state_d;

  // Output slot
  logic                  out_valid_q;
  logic [CW-1:0]         code_q, code_d;
  logic [K-2:0]          ostate_q;
  logic                  last_q, last_d;

  // Handshake and beat qualifiers
  logic                  slot_free;
  logic                  run_fire;
  logic                  tail_fire;
  logic                  load;
  logic                  run_end;
  logic                  tail_end;
  logic [RADIX_BITS-1:0] beat_bits;

  // State after each serial bit of the beat; [0] is the state entering it.
  logic [RADIX_BITS:0][K-2:0]            chain;
  logic [RADIX_BITS-1:0][N_POLY-1:0]     step_code;

  // The slot accepts a new beat when empty or being drained this cycle.
  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = (fsm_q == ST_RUN) && en_conv && slot_free;
  assign run_fire  = in_ready && in_valid;
  assign tail_fire = (fsm_q == ST_TAIL) && en_conv && slot_free;
  assign load      = run_fire || tail_fire;

  assign cnt_d    = cnt_q + LEN_W'(1);
  assign tail_d   = tail_q + TC_W'(1);
  assign run_end  = (cnt_d == len_q);
  assign tail_end = (tail_q == TAIL_LAST);

  // Tail beats shift in zeros, which also zero any padding bits.
  assign beat_bits = (fsm_q == ST_RUN) ? i_bit : '0;

  assign chain[0] = enc_state_q;

  // MSB of the beat is earliest, so step 0 takes the MSB and its code group
  // lands in the upper bits of the code word.
  genvar gi;
  generate
    for (gi = 0; gi < RADIX_BITS; gi++) begin : g_step
      conv_step #(
        .K      (K),
        .N_POLY (N_POLY)
      ) u_step (
        .state_i (chain[gi]),
        .bit_i   (beat_bits[RADIX_BITS-1-gi]),
        .poly_i  (poly_q),
        .code_o  (step_code[RADIX_BITS-1-gi]),
        .state_o (chain[gi+1])
      );
    end
  endgenerate

  assign code_d      = step_code;
  assign enc_state_d = chain[RADIX_BITS];
  // Truncated frames end on the last data beat; terminated ones on the last tail beat.
  assign last_d      = run_fire ? (run_end && !mode_q) : tail_end;

  // Frame sequencing: parameter latch, beat and tail counters, encoder state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q       <= ST_IDLE;
      poly_q      <= '0;
      mode_q      <= 1'b0;
      len_q       <= '0;
      cnt_q       <= '0;
      tail_q      <= '0;
      enc_state_q <= '0;
    end else begin
      case (fsm_q)
        ST_IDLE: begin
          if (en_conv && start && (frame_len != '0)) begin
            poly_q      <= polynomial;
            mode_q      <= mode_select;
            len_q       <= frame_len;
            cnt_q       <= '0;
            tail_q      <= '0;
            enc_state_q <= '0;
            fsm_q       <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (run_fire) begin
            enc_state_q <= enc_state_d;
            cnt_q       <= cnt_d;
            if (run_end) begin
              fsm_q <= mode_q ? ST_TAIL : ST_IDLE;
            end
          end
        end
        ST_TAIL: begin
          if (tail_fire) begin
            enc_state_q <= enc_state_d;
            tail_q      <= tail_d;
            if (tail_end) begin
              fsm_q <= ST_IDLE;
            end
          end
        end
        default: fsm_q <= ST_IDLE;
      endcase
    end
  end

  // Output slot: loads a produced beat, otherwise drains on out_ready; data holds after drain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      code_q      <= '0;
      ostate_q    <= '0;
      last_q      <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      code_q      <= code_d;
      ostate_q    <= enc_state_d;
      last_q      <= last_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign code_word = code_q;
  assign out_state = ostate_q;
  assign out_last  = last_q;
  assign busy      = (fsm_q != ST_IDLE);

endmodule

// File: tb/tb_conv_encoder_radix.sv
// Bench for conv_encoder_radix: one encoder instance per K in 3..9
// (N_POLY=2, RADIX_BITS=2), a selector steering stimulus to one of them,
// table-driven directed frames, hand-written control corner cases and
// randomized frames checked against a tap-sum reference model.
module tb_conv_encoder_radix;

  localparam int NI = 7;   // instance gi has K = gi + 3

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en_conv = 1'b1;
  logic start = 1'b0;
  logic [15:0] frame_len = '0;
  logic mode = 1'b0;
  logic [8:0] g0 = '0, g1 = '0;
  logic in_valid = 1'b0;
  logic [1:0] i_bit = '0;
  logic out_ready = 1'b1;
  logic [2:0] sel = '0;

  logic [NI-1:0] ir_a, ov_a, ol_a, bz_a;
  logic [3:0] cw_a [NI];
  logic [7:0] st_a [NI];

  logic in_ready, out_valid, out_last, busy;
  logic [3:0] code_word;
  logic [7:0] out_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] cw;
    logic [7:0] st;
    logic       last;
  } exp_t;

  typedef struct {
    int         frame;
    logic [1:0] din;
    logic [3:0] cw;
    logic [7:0] st;
    logic       last;
  } vec_t;

  typedef struct {
    int         s;
    logic [8:0] a0;
    logic [8:0] a1;
    logic       md;
    int         len;
    string      tag;
  } frm_t;

  logic [1:0] din_q [$];
  exp_t       exp_q [$];
  logic       u_q   [$];

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_dut
      localparam int KK = gi + 3;
      logic [2*KK-1:0] poly_v;
      logic [KK-2:0]   st_v;
      logic [3:0]      cw_v;
      logic            ir_v, ov_v, ol_v, bz_v;
      assign poly_v = {g1[KK-1:0], g0[KK-1:0]};
      conv_encoder_radix #(
        .K          (KK),
        .N_POLY     (2),
        .RADIX_BITS (2),
        .LEN_W      (16)
      ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .en_conv     (en_conv),
        .start       (start && (sel == 3'(gi))),
        .frame_len   (frame_len),
        .mode_select (mode),
        .polynomial  (poly_v),
        .in_valid    (in_valid && (sel == 3'(gi))),
        .in_ready    (ir_v),
        .i_bit       (i_bit),
        .out_valid   (ov_v),
        .out_ready   (out_ready),
        .code_word   (cw_v),
        .out_state   (st_v),
        .out_last    (ol_v),
        .busy        (bz_v)
      );
      assign ir_a[gi] = ir_v;
      assign ov_a[gi] = ov_v;
      assign ol_a[gi] = ol_v;
      assign bz_a[gi] = bz_v;
      assign cw_a[gi] = cw_v;
      assign st_a[gi] = 8'(st_v);
    end
  endgenerate

  assign in_ready  = ir_a[sel];
  assign out_valid = ov_a[sel];
  assign out_last  = ol_a[sel];
  assign busy      = bz_a[sel];
  assign code_word = cw_a[sel];
  assign out_state = st_a[sel];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: bit stream u, generator j output at time t is the
  // parity of g_j[K-1-d] & u[t-d]; state after t holds u[t] down to u[t-K+2].
  function automatic logic u_at(input int idx);
    return (idx < 0) ? 1'b0 : u_q[idx];
  endfunction

  function automatic logic gen_out(input int kk, input logic [8:0] g, input int t);
    logic c;
    c = 1'b0;
    for (int d = 0; d < kk; d++) c = c ^ (g[kk-1-d] & u_at(t - d));
    return c;
  endfunction

  task automatic build_exp(input int kk, input logic [8:0] a0, input logic [8:0] a1,
                           input logic md, input int len);
    int nb;
    exp_t e;
    u_q.delete();
    exp_q.delete();
    for (int b = 0; b < len; b++) begin
      u_q.push_back(din_q[b][1]);
      u_q.push_back(din_q[b][0]);
    end
    nb = len + (md ? kk / 2 : 0);
    while (u_q.size() < 2 * nb) u_q.push_back(1'b0);
    for (int b = 0; b < nb; b++) begin
      e.cw = {gen_out(kk, a0, 2*b), gen_out(kk, a1, 2*b),
              gen_out(kk, a0, 2*b+1), gen_out(kk, a1, 2*b+1)};
      e.st = '0;
      for (int s = 0; s < kk - 1; s++) e.st[kk-2-s] = u_at(2*b + 1 - s);
      e.last = (b == nb - 1);
      exp_q.push_back(e);
    end
  endtask

  // Runs one frame on instance s against exp_q. rdy_mode: 0 always ready,
  // 1 random valid/ready, 2 ready dropped for cycles 3..7.
  task automatic run_frame(input int s, input logic [8:0] a0, input logic [8:0] a1,
                           input logic md, input int len, input int rdy_mode,
                           input bit en_drop, input bit start_mid, input bit verbose,
                           input string tag);
    int bi, oi, cyc, budget, drop_cyc;
    logic [3:0] held_cw;
    sel = 3'(s); g0 = a0; g1 = a1; mode = md; frame_len = 16'(len);
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1; en_conv = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bi = 0; oi = 0; cyc = 0; drop_cyc = -1; held_cw = '0;
    budget = 100 + 30 * (len + 8);
    while (oi < exp_q.size() && cyc < budget) begin
      in_valid = (bi < len) && (rdy_mode != 1 || $urandom_range(0, 3) != 0);
      i_bit = (bi < len) ? din_q[bi] : 2'b00;
      if (rdy_mode == 0) out_ready = 1'b1;
      else if (rdy_mode == 1) out_ready = ($urandom_range(0, 2) != 0);
      else out_ready = !(cyc >= 3 && cyc < 8);
      if (en_drop && bi == len && drop_cyc < 0) drop_cyc = 0;
      en_conv = !(drop_cyc >= 0 && drop_cyc < 3);
      if (start_mid && cyc == 2) begin
        start = 1'b1; frame_len = 16'd1; g0 = ~a0; mode = ~md;
      end else begin
        start = 1'b0;
      end
      #1;
      if (cyc == 0) chk({tag, "_first_in_ready"}, {busy, in_ready}, 2'b11);
      if (rdy_mode == 2 && cyc >= 3 && cyc < 8) chk({tag, "_stall_in_ready"}, in_ready, 1'b0);
      if (rdy_mode == 2 && cyc == 3) held_cw = code_word;
      if (rdy_mode == 2 && cyc > 3 && cyc < 8) chk({tag, "_stall_hold"}, {out_valid, code_word}, {1'b1, held_cw});
      if (drop_cyc >= 1 && drop_cyc <= 3) chk({tag, "_en_drop_pause"}, {out_valid, busy}, 2'b01);
      if (out_valid && out_ready) begin
        chk($sformatf("%s_beat%0d", tag, oi), {code_word, out_state, out_last},
            {exp_q[oi].cw, exp_q[oi].st, exp_q[oi].last});
        if (out_last) chk({tag, "_busy_fall"}, busy, 1'b0);
        if (verbose)
          $display("%s beat %0d: cw=%b st=%b last=%b", tag, oi, code_word, out_state, out_last);
        oi++;
      end
      if (in_valid && in_ready) bi++;
      if (drop_cyc >= 0) drop_cyc++;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0; en_conv = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    chk({tag, "_beat_count"}, oi, exp_q.size());
    @(negedge clk);
    #1;
    chk({tag, "_no_extra_beat"}, {out_valid, busy}, 2'b00);
  endtask

  vec_t vt[8];
  frm_t ft[3];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [8:0] a0, a1;
    logic md;
    int len, s, kk;
    exp_t e;

    // Directed frames: K=3 7/5 octal truncated and terminated, K=4 17/13 odd tail.
    ft[0] = '{0, 9'b111, 9'b101, 1'b0, 2, "basic_m0"};
    ft[1] = '{0, 9'b111, 9'b101, 1'b1, 2, "zero_tail"};
    ft[2] = '{1, 9'b1111, 9'b1011, 1'b1, 1, "odd_tail"};
    vt[0] = '{0, 2'b10, 4'b1110, 8'h01, 1'b0};
    vt[1] = '{0, 2'b11, 4'b0001, 8'h03, 1'b1};
    vt[2] = '{1, 2'b10, 4'b1110, 8'h01, 1'b0};
    vt[3] = '{1, 2'b11, 4'b0001, 8'h03, 1'b0};
    vt[4] = '{1, 2'b00, 4'b0111, 8'h00, 1'b1};
    vt[5] = '{2, 2'b11, 4'b1101, 8'h06, 1'b0};
    vt[6] = '{2, 2'b00, 4'b0100, 8'h01, 1'b0};
    vt[7] = '{2, 2'b00, 4'b1100, 8'h00, 1'b1};

    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", {out_valid, code_word, out_state, out_last, busy, in_ready}, '0);
    rst = 1'b1;
    @(negedge clk);

    for (int f = 0; f < 3; f++) begin
      din_q.delete();
      exp_q.delete();
      for (int v = 0; v < 8; v++) begin
        if (vt[v].frame == f) begin
          if (din_q.size() < ft[f].len) din_q.push_back(vt[v].din);
          e.cw = vt[v].cw; e.st = vt[v].st; e.last = vt[v].last;
          exp_q.push_back(e);
        end
      end
      run_frame(ft[f].s, ft[f].a0, ft[f].a1, ft[f].md, ft[f].len, 0, 1'b0, 1'b0, 1'b1, ft[f].tag);
    end

    // Backpressure mid-frame plus an ignored start with altered parameters.
    a0 = 9'($urandom); a1 = 9'($urandom);
    din_q.delete();
    for (int b = 0; b < 8; b++) din_q.push_back(2'($urandom));
    build_exp(5, a0, a1, 1'b0, 8);
    run_frame(2, a0, a1, 1'b0, 8, 2, 1'b0, 1'b1, 1'b1, "stall");

    // en_conv dropped for 3 cycles as the K=9 tail begins.
    a0 = 9'($urandom); a1 = 9'($urandom);
    din_q.delete();
    for (int b = 0; b < 3; b++) din_q.push_back(2'($urandom));
    build_exp(9, a0, a1, 1'b1, 3);
    run_frame(6, a0, a1, 1'b1, 3, 0, 1'b1, 1'b0, 1'b1, "en_drop");

    // start with frame_len = 0 is ignored.
    sel = 3'd0; frame_len = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("len0_ignored", {busy, in_ready}, 2'b00);
    @(negedge clk);
    #1;
    chk("len0_still_idle", {busy, out_valid}, 2'b00);
    $display("len0: busy=%b", busy);

    // Reset mid-frame with a pending output beat.
    @(negedge clk);
    sel = 3'd6; g0 = 9'h1ED; g1 = 9'h12B; mode = 1'b0; frame_len = 16'd6;
    start = 1'b1; out_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; i_bit = 2'b11;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("rst_pre_pending", {out_valid, busy}, 2'b11);
    rst = 1'b0;
    #1;
    chk("rst_async_clear", {out_valid, code_word, out_state, out_last, busy, in_ready}, '0);
    @(negedge clk);
    #1;
    chk("rst_after_edge", {out_valid, code_word, out_state, out_last, busy, in_ready}, '0);
    $display("reset: outputs cleared, busy=%b", busy);
    rst = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    a0 = 9'h1ED; a1 = 9'h12B;
    din_q.delete();
    for (int b = 0; b < 6; b++) din_q.push_back(2'($urandom));
    build_exp(9, a0, a1, 1'b1, 6);
    run_frame(6, a0, a1, 1'b1, 6, 0, 1'b0, 1'b0, 1'b1, "post_rst");

    // Random stress: random K, polynomials, mode, length and handshakes.
    for (int fr = 0; fr < 1000; fr++) begin
      s = $urandom_range(0, NI - 1);
      kk = s + 3;
      a0 = 9'($urandom); a1 = 9'($urandom);
      md = 1'($urandom);
      len = $urandom_range(1, 10);
      din_q.delete();
      for (int b = 0; b < len; b++) din_q.push_back(2'($urandom));
      build_exp(kk, a0, a1, md, len);
      run_frame(s, a0, a1, md, len, 1, 1'b0, 1'b0, 1'b0, $sformatf("rnd%0d", fr));
      $display("frame %0d: K=%0d len=%0d mode=%0d beats=%0d", fr, kk, len, md, exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_encoder_radix.md
# conv_encoder_radix

Parametrised streaming convolutional encoder for the Viterbi datapath. It encodes rate-1/N_POLY codes with constraint length up to 9, and consumes RADIX_BITS input bits per beat. It runs framed transfers with a frame-length counter and optional zero-tail termination, over valid/ready handshakes. Each output beat carries the code word and the resulting encoder state, so the decoder-side trellis checker can consume it directly.

## Interface
- K, 9: constraint length, 3..9; state is K-1 bits.
- N_POLY, 2: generator polynomials (code rate 1/N_POLY), 2..4.
- RADIX_BITS, 2: input bits per beat, 1 or 2.
- LEN_W, 16: frame-length counter width.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- en_conv  in  1  global enable; 0 freezes all state, counters and outputs.
- start  in  1  frame start pulse, sampled in IDLE only.
- frame_len  in  LEN_W  data beats per frame, latched on start.
- mode_select  in  1  latched on start; 0 = truncated, 1 = zero-tail terminated.
- polynomial  in  N_POLY*K  generator j at [j*K +: K], latched on start; bit K-1 taps the current input, bit K-2 the newest state bit, bit 0 the oldest.
- in_valid / in_ready  in / out  1  input handshake.
- i_bit  in  RADIX_BITS  data; MSB is earliest in time.
- out_valid / out_ready  out / in  1  output handshake.
- code_word  out  RADIX_BITS*N_POLY  earliest bit's group in the upper bits; within a group, generator 0 is MSB.
- out_state  out  K-1  encoder state after the beat; [K-2] = most recent bit.
- out_last  out  1  final beat of frame.
- busy  out  1  high when not IDLE.

## Operation
- FSM states: IDLE, RUN, TAIL.
- IDLE:
  - On start with en_conv=1 and frame_len≠0: latch polynomial, mode_select and frame_len; clear state and beat counter; go to RUN.
  - start with frame_len=0 is ignored.
- RUN:
  - in_ready = en_conv & (!out_valid | out_ready).
  - Each accepted beat processes its RADIX_BITS bits serially, MSB first.
  - Per bit: sr = {bit, state}; c_j = XOR-reduce(sr & poly_j); next state = sr[K-1:1].
  - After the beat whose count equals frame_len: with mode 0, set out_last and go to IDLE; with mode 1, go to TAIL.
- TAIL:
  - Emits ceil((K-1)/RADIX_BITS) beats of all-zero input, one per cycle when the output slot is free and en_conv=1.
  - Padding bits beyond K-1 are also zero; the state remains zero.
  - out_last on the final tail beat, then go to IDLE.
- start in RUN or TAIL is ignored; latched parameters are stable for the whole frame.
- Output register:
  - out_valid, code_word, out_state and out_last hold until out_ready.
  - A new beat loads only when the slot is empty or being drained in the same cycle.
- en_conv=0:
  - in_ready=0; no tail beats are generated; FSM and counter hold.
  - out_valid and the output data hold; out_ready is still honoured, so a pending beat may drain.
- Reset mid-frame returns to IDLE immediately and discards the frame.

## Timing
- Reset values: all outputs 0; FSM in IDLE; state, counter and latched parameters 0.
- Latency: an input accepted at edge n gives out_valid=1 after edge n.
- Throughput: 1 beat/cycle with out_ready held high, including back-to-back RUN→TAIL.
- First in_ready: the cycle after start is sampled.
- After a frame: busy falls on the edge that loads the out_last beat. The next start is accepted the following cycle, even while that beat is still pending.

## Structure
- Shared package conv_pkg:
  - K_MAX=9 and the FSM state enum.
  - Function conv_parity(sr, poly).
- Sub-module conv_step: combinational single-bit step (state, bit, polys → N_POLY outputs, next state), instantiated RADIX_BITS times in a chain.

## Test plan
- Basic encode. K=3, N_POLY=2, RADIX_BITS=2, polys 7/5 octal (3'b111, 3'b101), mode 0, frame_len=2, i_bit 2'b10 then 2'b11:
  - code_word 4'b1110 with out_state 2'b01.
  - Then 4'b0001 with out_state 2'b11, out_last=1.
- Zero-tail. Same frame with mode 1:
  - One extra beat, code_word 4'b0111, out_state 2'b00, out_last=1.
- Odd tail length. K=4, RADIX_BITS=2, mode 1:
  - Exactly 2 tail beats.
  - Final out_state 3'b000.
- Backpressure. out_ready low for 5 cycles mid-frame:
  - in_ready=0 throughout.
  - code_word held stable.
  - No beat lost or duplicated against the reference model.
- Control corner cases:
  - en_conv dropped for 3 cycles during TAIL: tail beats pause, then resume.
  - start during RUN: ignored.
  - start with frame_len=0: busy stays 0.
- Reset and random stress:
  - rst asserted mid-frame with out_valid=1: all outputs 0 on the following edge; a new frame then encodes correctly.
  - Random K, polys and frame_len vs. a reference model: 1000 frames match.
